// File: rtl/pic_host_controller.sv
`default_nettype none
// ============================================================================
// pic_host_controller: bus initiator for an 8259 PIC (ICW init, OCW/status, INTA)
// Optional macro PIC_HOST_AUTO_EOI_EN: non-specific EOI after each INTA cycle.
// Revision: 1.0
// ============================================================================
module pic_host_controller #(
    parameter logic [7:0] ICW1         = 8'h11,
    parameter logic [7:0] ICW2         = 8'h08,
    parameter logic [7:0] ICW3         = 8'h3F,
    parameter logic [7:0] ICW4         = 8'h00,
    parameter int         PULSE_CYCLES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start_init,
    output logic       init_done,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_read,
    input  logic       cmd_a0,
    input  logic [7:0] cmd_data,
    output logic       rd_valid,
    output logic [7:0] rd_data,
    input  logic       INT_Flag,
    output logic       vector_valid,
    output logic [7:0] vector,
    output logic       chip_select,
    output logic       write_flag,
    output logic       read_flag,
    output logic       INTA,
    output logic       A0,
    output logic [7:0] data_out,
    output logic       data_oe,
    input  logic [7:0] data_in
);

    localparam int            CW         = (PULSE_CYCLES > 1) ? $clog2(PULSE_CYCLES) : 1;
    localparam logic [CW-1:0] c_CNT_LOAD = CW'(PULSE_CYCLES - 1);

    typedef enum logic [3:0] {
        S_IDLE, S_SETUP, S_STROBE, S_HOLD, S_GAP,
        S_INTA1, S_INTA_GAP, S_INTA2, S_DONE
    } state_t;

    state_t        r_state;
    logic [CW-1:0] r_cnt;
    logic [1:0]    r_idx;
    logic          r_in_init, r_init_pend, r_init_done, r_is_read;
    logic          r_cs, r_wr, r_rd, r_inta, r_a0, r_oe;
    logic [7:0]    r_dout, r_rd_data, r_vector;
    logic          r_rd_valid, r_vector_valid;

    logic          w_init_req, w_init_last;
    logic [1:0]    w_next_idx;

    function automatic logic [7:0] icw_word(input logic [1:0] idx);
        case (idx)
            2'd0:    icw_word = ICW1;
            2'd1:    icw_word = ICW2;
            2'd2:    icw_word = ICW3;
            default: icw_word = ICW4;
        endcase
    endfunction

    assign w_init_req = start_init | r_init_pend;

    // ICW3 only in cascade mode (SNGL=0), ICW4 only when IC4=1
    always_comb begin
        w_next_idx  = r_idx;
        w_init_last = 1'b1;
        case (r_idx)
            2'd0: begin
                w_next_idx  = 2'd1;
                w_init_last = 1'b0;
            end
            2'd1: begin
                if (!ICW1[1]) begin
                    w_next_idx  = 2'd2;
                    w_init_last = 1'b0;
                end else if (ICW1[0]) begin
                    w_next_idx  = 2'd3;
                    w_init_last = 1'b0;
                end
            end
            2'd2: begin
                if (ICW1[0]) begin
                    w_next_idx  = 2'd3;
                    w_init_last = 1'b0;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state        <= S_IDLE;
            r_cnt          <= '0;
            r_idx          <= 2'd0;
            r_in_init      <= 1'b0;
            r_init_pend    <= 1'b0;
            r_init_done    <= 1'b0;
            r_is_read      <= 1'b0;
            r_cs           <= 1'b1;
            r_wr           <= 1'b1;
            r_rd           <= 1'b1;
            r_inta         <= 1'b1;
            r_a0           <= 1'b0;
            r_oe           <= 1'b0;
            r_dout         <= 8'h00;
            r_rd_data      <= 8'h00;
            r_vector       <= 8'h00;
            r_rd_valid     <= 1'b0;
            r_vector_valid <= 1'b0;
        end else begin
            r_rd_valid     <= 1'b0;
            r_vector_valid <= 1'b0;
            if (start_init && r_state != S_IDLE)
                r_init_pend <= 1'b1;
            case (r_state)
                S_IDLE: begin
                    if (w_init_req) begin
                        r_init_pend <= 1'b0;
                        r_init_done <= 1'b0;
                        r_in_init   <= 1'b1;
                        r_idx       <= 2'd0;
                        r_is_read   <= 1'b0;
                        r_cs        <= 1'b0;
                        r_a0        <= 1'b0;
                        r_dout      <= ICW1;
                        r_oe        <= 1'b1;
                        r_state     <= S_SETUP;
                    end else if (INT_Flag && r_init_done) begin
                        r_inta  <= 1'b0;
                        r_cnt   <= c_CNT_LOAD;
                        r_state <= S_INTA1;
                    end else if (cmd_valid && r_init_done) begin
                        r_in_init <= 1'b0;
                        r_is_read <= cmd_read;
                        r_cs      <= 1'b0;
                        r_a0      <= cmd_a0;
                        r_dout    <= cmd_data;
                        r_oe      <= !cmd_read;
                        r_state   <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    if (r_is_read) r_rd <= 1'b0;
                    else           r_wr <= 1'b0;
                    r_cnt   <= c_CNT_LOAD;
                    r_state <= S_STROBE;
                end
                S_STROBE: begin
                    if (r_cnt == '0) begin
                        r_wr <= 1'b1;
                        r_rd <= 1'b1;
                        if (r_is_read) begin
                            r_rd_data  <= data_in;
                            r_rd_valid <= 1'b1;
                        end
                        r_state <= S_HOLD;
                    end else begin
                        r_cnt <= r_cnt - CW'(1);
                    end
                end
                S_HOLD: begin
                    r_cs    <= 1'b1;
                    r_oe    <= 1'b0;
                    r_state <= S_GAP;
                end
                S_GAP: begin
                    // A newly requested init abandons the running sequence via IDLE
                    if (r_in_init && !w_init_last && !w_init_req) begin
                        r_idx   <= w_next_idx;
                        r_cs    <= 1'b0;
                        r_a0    <= 1'b1;
                        r_dout  <= icw_word(w_next_idx);
                        r_oe    <= 1'b1;
                        r_state <= S_SETUP;
                    end else begin
                        if (r_in_init && w_init_last)
                            r_init_done <= 1'b1;
                        r_in_init <= 1'b0;
                        r_state   <= S_IDLE;
                    end
                end
                S_INTA1: begin
                    if (r_cnt == '0) begin
                        r_inta  <= 1'b1;
                        r_cnt   <= c_CNT_LOAD;
                        r_state <= S_INTA_GAP;
                    end else begin
                        r_cnt <= r_cnt - CW'(1);
                    end
                end
                S_INTA_GAP: begin
                    if (r_cnt == '0) begin
                        r_inta  <= 1'b0;
                        r_cnt   <= c_CNT_LOAD;
                        r_state <= S_INTA2;
                    end else begin
                        r_cnt <= r_cnt - CW'(1);
                    end
                end
                S_INTA2: begin
                    if (r_cnt == '0) begin
                        r_inta         <= 1'b1;
                        r_vector       <= data_in;
                        r_vector_valid <= 1'b1;
                        r_state        <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt - CW'(1);
                    end
                end
                S_DONE: begin
`ifdef PIC_HOST_AUTO_EOI_EN
                    r_in_init <= 1'b0;
                    r_is_read <= 1'b0;
                    r_cs      <= 1'b0;
                    r_a0      <= 1'b0;
                    r_dout    <= 8'h20;
                    r_oe      <= 1'b1;
                    r_state   <= S_SETUP;
`else
                    r_state   <= S_IDLE;
`endif
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign cmd_ready    = (r_state == S_IDLE) && r_init_done && !INT_Flag && !w_init_req;
    assign init_done    = r_init_done;
    assign rd_valid     = r_rd_valid;
    assign rd_data      = r_rd_data;
    assign vector_valid = r_vector_valid;
    assign vector       = r_vector;
    assign chip_select  = r_cs;
    assign write_flag   = r_wr;
    assign read_flag    = r_rd;
    assign INTA         = r_inta;
    assign A0           = r_a0;
    assign data_out     = r_dout;
    assign data_oe      = r_oe;

endmodule
`default_nettype wire

// File: tb/tb_pic_host_controller.sv
`default_nettype none
// ============================================================================
// tb_pic_host_controller: directed self-checking bench for pic_host_controller
// Revision: 1.0
// ============================================================================
module tb_pic_host_controller;

    logic       clk = 1'b0, reset = 1'b1;
    logic       start_init = 1'b0, start_init_b = 1'b0, zero = 1'b0;
    logic       cmd_valid = 1'b0, cmd_read = 1'b0, cmd_a0 = 1'b0, INT_Flag = 1'b0;
    logic [7:0] cmd_data = 8'h00, data_in = 8'h00;

    logic       init_done, cmd_ready, rd_valid, vector_valid;
    logic       chip_select, write_flag, read_flag, INTA, A0, data_oe;
    logic [7:0] rd_data, vector, data_out;

    logic       init_done_b, cmd_ready_b, rd_valid_b, vector_valid_b;
    logic       chip_select_b, write_flag_b, read_flag_b, INTA_b, A0_b, data_oe_b;
    logic [7:0] rd_data_b, vector_b, data_out_b;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    pic_host_controller u_dut (
        .clk(clk), .reset(reset), .start_init(start_init), .init_done(init_done),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_read(cmd_read),
        .cmd_a0(cmd_a0), .cmd_data(cmd_data), .rd_valid(rd_valid), .rd_data(rd_data),
        .INT_Flag(INT_Flag), .vector_valid(vector_valid), .vector(vector),
        .chip_select(chip_select), .write_flag(write_flag), .read_flag(read_flag),
        .INTA(INTA), .A0(A0), .data_out(data_out), .data_oe(data_oe), .data_in(data_in)
    );

    pic_host_controller #(.ICW1(8'h13)) u_dut_b (
        .clk(clk), .reset(reset), .start_init(start_init_b), .init_done(init_done_b),
        .cmd_valid(zero), .cmd_ready(cmd_ready_b), .cmd_read(zero),
        .cmd_a0(zero), .cmd_data(cmd_data), .rd_valid(rd_valid_b), .rd_data(rd_data_b),
        .INT_Flag(zero), .vector_valid(vector_valid_b), .vector(vector_b),
        .chip_select(chip_select_b), .write_flag(write_flag_b), .read_flag(read_flag_b),
        .INTA(INTA_b), .A0(A0_b), .data_out(data_out_b), .data_oe(data_oe_b), .data_in(data_in)
    );

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        total++;
        if ({chip_select, write_flag, read_flag, INTA} !== 4'hF) begin
            bad++; $display("FAIL reset_strobes: got %b want 1111", {chip_select, write_flag, read_flag, INTA});
        end
        total++;
        if ({A0, data_oe, data_out} !== 10'h000) begin
            bad++; $display("FAIL reset_bus: got %h want 000", {A0, data_oe, data_out});
        end
        total++;
        if ({init_done, cmd_ready, rd_valid, vector_valid} !== 4'h0) begin
            bad++; $display("FAIL reset_status: got %b want 0000", {init_done, cmd_ready, rd_valid, vector_valid});
        end
        total++;
        if ({rd_data, vector} !== 16'h0000) begin
            bad++; $display("FAIL reset_data: got %h want 0000", {rd_data, vector});
        end
        reset = 1'b0;
        cmd_valid = 1'b1; cmd_data = 8'h0A;
        repeat (3) begin
            @(negedge clk);
            total++;
            if (cmd_ready !== 1'b0 || chip_select !== 1'b1) begin
                bad++; $display("FAIL cmd_before_init: got ready=%b cs=%b want ready=0 cs=1", cmd_ready, chip_select);
            end
        end
        cmd_valid = 1'b0;
    endtask

    task automatic test_init_default();
        logic [8:0] exp_w [4] = '{9'h011, 9'h108, 9'h13F, 9'h100};
        logic [8:0] got[$];
        int         wid[$];
        int         cyc = 0, lw = 0;
        logic       pw = 1'b1;
        start_init = 1'b1;
        @(negedge clk);
        start_init = 1'b0;
        while (init_done !== 1'b1 && cyc < 60) begin
            @(negedge clk); cyc++;
            if (write_flag === 1'b0) begin
                if (pw) got.push_back({A0, data_out});
                lw++;
            end else if (!pw) begin
                wid.push_back(lw); lw = 0;
            end
            pw = write_flag;
        end
        total++;
        if (cyc !== 20) begin
            bad++; $display("FAIL init_latency: got %0d want 20", cyc);
        end
        total++;
        if (got.size() !== 4 || wid.size() !== 4) begin
            bad++; $display("FAIL init_count: got %0d/%0d want 4", got.size(), wid.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                total++;
                if (got[i] !== exp_w[i] || wid[i] !== 2) begin
                    bad++; $display("FAIL init_word%0d: got %h w=%0d want %h w=2", i, got[i], wid[i], exp_w[i]);
                end
            end
        end
    endtask

    task automatic test_init_skip();
        logic [8:0] exp_w [3] = '{9'h013, 9'h108, 9'h100};
        logic [8:0] got[$];
        int         cyc = 0;
        logic       pw = 1'b1;
        start_init_b = 1'b1;
        @(negedge clk);
        start_init_b = 1'b0;
        while (init_done_b !== 1'b1 && cyc < 60) begin
            @(negedge clk); cyc++;
            if (write_flag_b === 1'b0 && pw) got.push_back({A0_b, data_out_b});
            pw = write_flag_b;
        end
        total++;
        if (cyc !== 15) begin
            bad++; $display("FAIL skip_latency: got %0d want 15", cyc);
        end
        total++;
        if (got.size() !== 3) begin
            bad++; $display("FAIL skip_count: got %0d want 3", got.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                total++;
                if (got[i] !== exp_w[i]) begin
                    bad++; $display("FAIL skip_word%0d: got %h want %h", i, got[i], exp_w[i]);
                end
            end
        end
    endtask

    task automatic test_write_read();
        int   cyc = 0, wl = 0, rl = 0, npulse = 0;
        logic oe_seen = 1'b0;
        logic [7:0] rv = 8'h00;
        total++;
        if (cmd_ready !== 1'b1) begin
            bad++; $display("FAIL ready_after_init: got %b want 1", cmd_ready);
        end
        cmd_valid = 1'b1; cmd_read = 1'b0; cmd_a0 = 1'b0; cmd_data = 8'h0A;
        @(negedge clk);
        cmd_valid = 1'b0;
        total++;
        if ({chip_select, data_oe, A0, data_out} !== {1'b0, 1'b1, 1'b0, 8'h0A}) begin
            bad++; $display("FAIL write_setup: got %h want 10a", {chip_select, data_oe, A0, data_out});
        end
        while (cmd_ready !== 1'b1 && cyc < 20) begin
            @(negedge clk); cyc++;
            if (write_flag === 1'b0) wl++;
        end
        total++;
        if (cyc !== 5 || wl !== 2) begin
            bad++; $display("FAIL write_timing: got cyc=%0d low=%0d want cyc=5 low=2", cyc, wl);
        end
        data_in = 8'h10;
        cmd_valid = 1'b1; cmd_read = 1'b1; cmd_a0 = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0; cmd_read = 1'b0;
        cyc = 0;
        while (cmd_ready !== 1'b1 && cyc < 20) begin
            if (read_flag === 1'b0) rl++;
            if (data_oe !== 1'b0) oe_seen = 1'b1;
            if (rd_valid === 1'b1) begin npulse++; rv = rd_data; end
            @(negedge clk); cyc++;
        end
        data_in = 8'h00;
        total++;
        if (npulse !== 1 || rv !== 8'h10) begin
            bad++; $display("FAIL read_data: got pulses=%0d data=%h want 1 10", npulse, rv);
        end
        total++;
        if (rl !== 2 || oe_seen !== 1'b0) begin
            bad++; $display("FAIL read_strobe: got low=%0d oe=%b want 2 0", rl, oe_seen);
        end
        total++;
        if (rd_data !== 8'h10) begin
            bad++; $display("FAIL read_hold: got %h want 10", rd_data);
        end
    endtask

    task automatic test_inta();
        int   cyc = 0, lowrun = 0, gap = 0, nvv = 0;
        int   w[$];
        logic pinta = 1'b1, pw = 1'b1, seen_vv = 1'b0, cs_bad = 1'b0;
        logic [7:0] vec = 8'h00;
        logic [8:0] wr[$];
        data_in = 8'h0C; INT_Flag = 1'b1;
        @(negedge clk);
        INT_Flag = 1'b0;
        while (cmd_ready !== 1'b1 && cyc < 40) begin
            if (!seen_vv && (chip_select !== 1'b1 || data_oe !== 1'b0)) cs_bad = 1'b1;
            if (INTA === 1'b0) lowrun++;
            else if (!pinta) begin w.push_back(lowrun); lowrun = 0; end
            if (INTA === 1'b1 && w.size() == 1) gap++;
            if (vector_valid === 1'b1) begin nvv++; vec = vector; seen_vv = 1'b1; end
            if (write_flag === 1'b0 && pw) wr.push_back({A0, data_out});
            pw = write_flag; pinta = INTA;
            @(negedge clk); cyc++;
        end
        data_in = 8'h00;
        total++;
        if (w.size() !== 2 || w[0] !== 2 || w[1] !== 2 || gap !== 2) begin
            bad++; $display("FAIL inta_pulses: got n=%0d gap=%0d want n=2 w=2 gap=2", w.size(), gap);
        end
        total++;
        if (nvv !== 1 || vec !== 8'h0C || vector !== 8'h0C) begin
            bad++; $display("FAIL inta_vector: got n=%0d vec=%h hold=%h want 1 0c 0c", nvv, vec, vector);
        end
        total++;
        if (cs_bad !== 1'b0) begin
            bad++; $display("FAIL inta_bus_idle: got %b want 0", cs_bad);
        end
`ifdef PIC_HOST_AUTO_EOI_EN
        total++;
        if (wr.size() !== 1 || wr[0] !== 9'h020 || cyc !== 12) begin
            bad++; $display("FAIL inta_eoi: got n=%0d cyc=%0d want n=1 word=020 cyc=12", wr.size(), cyc);
        end
`else
        total++;
        if (wr.size() !== 0 || cyc !== 7) begin
            bad++; $display("FAIL inta_no_eoi: got n=%0d cyc=%0d want n=0 cyc=7", wr.size(), cyc);
        end
`endif
    endtask

    task automatic test_priority();
        int   cyc = 0;
        logic seen_vv = 1'b0;
        data_in = 8'h55; INT_Flag = 1'b1;
        cmd_valid = 1'b1; cmd_read = 1'b0; cmd_a0 = 1'b1; cmd_data = 8'h0B;
        #1;
        total++;
        if (cmd_ready !== 1'b0) begin
            bad++; $display("FAIL prio_ready_low: got %b want 0", cmd_ready);
        end
        @(negedge clk);
        INT_Flag = 1'b0;
        total++;
        if (INTA !== 1'b0 || chip_select !== 1'b1) begin
            bad++; $display("FAIL prio_inta_first: got inta=%b cs=%b want 0 1", INTA, chip_select);
        end
        while (cmd_ready !== 1'b1 && cyc < 40) begin
            if (vector_valid === 1'b1) seen_vv = 1'b1;
            @(negedge clk); cyc++;
        end
        total++;
        if (seen_vv !== 1'b1 || vector !== 8'h55) begin
            bad++; $display("FAIL prio_vector: got seen=%b vec=%h want 1 55", seen_vv, vector);
        end
        @(negedge clk);
        cmd_valid = 1'b0;
        total++;
        if ({chip_select, data_oe, A0, data_out} !== {1'b0, 1'b1, 1'b1, 8'h0B}) begin
            bad++; $display("FAIL prio_cmd_after: got %h want 30b", {chip_select, data_oe, A0, data_out});
        end
        cyc = 0;
        while (cmd_ready !== 1'b1 && cyc < 20) begin
            @(negedge clk); cyc++;
        end
        data_in = 8'h00;
    endtask

    task automatic test_reset_mid();
        int cyc = 0;
        start_init = 1'b1;
        @(negedge clk);
        start_init = 1'b0;
        while (!(write_flag === 1'b0 && A0 === 1'b1) && cyc < 30) begin
            @(negedge clk); cyc++;
        end
        total++;
        if (data_out !== 8'h08) begin
            bad++; $display("FAIL mid_reach_icw2: got %h want 08", data_out);
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        total++;
        if ({write_flag, chip_select, data_oe, init_done} !== 4'b1100) begin
            bad++; $display("FAIL mid_reset_outputs: got %b want 1100", {write_flag, chip_select, data_oe, init_done});
        end
        @(negedge clk);
        total++;
        if (cmd_ready !== 1'b0 || chip_select !== 1'b1) begin
            bad++; $display("FAIL mid_reset_idle: got ready=%b cs=%b want 0 1", cmd_ready, chip_select);
        end
        test_init_default();
    endtask

    initial begin
        test_reset();
        test_init_default();
        test_init_skip();
        test_write_read();
        test_inta();
        test_priority();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
